// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes, data-memory waits.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_control_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic [4:0]  idex_rd,
  input  logic        idex_mem_read,
  input  logic        branch_taken_ex,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_hold,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cycles,
`endif
  output logic        mem_timeout
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
    logic mem_timeout;
  } ctl_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX   = 8'(MEM_TIMEOUT);
  localparam ctl_t CTL_DEF  = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
  localparam ctl_t CTL_HOLD = '{pipe_hold: 1'b1, default: 1'b0};
  localparam ctl_t CTL_FLSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                idex_bubble: 1'b1, default: 1'b0};
  localparam ctl_t CTL_LU   = '{idex_bubble: 1'b1, default: 1'b0};

  state_e     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       ret_flush_q, ret_flush_d;
  logic       lu, ms;
  ctl_t       ctl;

  always_comb begin
    lu = idex_mem_read && (idex_rd != 5'd0) &&
         ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));
    ms = mem_req && !mem_ready;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ret_flush_d = ret_flush_q;
    ctl         = CTL_DEF;
    case (state_q)
      RUN: begin
        if (ms) begin
          ctl        = CTL_HOLD;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (branch_taken_ex) begin
          ctl = CTL_FLSH;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (lu) begin
          ctl = CTL_LU;
        end
      end
      FLUSH: begin
        // A memory stall freezes the flush; flush_cnt resumes after the wait.
        if (ms) begin
          ctl         = CTL_HOLD;
          state_d     = MEM_WAIT;
          wait_cnt_d  = 8'd1;
          ret_flush_d = 1'b1;
        end else begin
          ctl = CTL_FLSH;
          if (flush_cnt_q <= 2'd1) begin
            state_d     = RUN;
            flush_cnt_d = 2'd0;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
      end
      MEM_WAIT: begin
        ctl = CTL_HOLD;
        if (mem_ready || (wait_cnt_q >= WAIT_MAX)) begin
          ctl.mem_timeout = !mem_ready;
          state_d         = ret_flush_q ? FLUSH : RUN;
          ret_flush_d     = 1'b0;
          wait_cnt_d      = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 2'd0;
      wait_cnt_q  <= 8'd0;
      ret_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      ret_flush_q <= ret_flush_d;
    end
  end

  // Outputs are gated low for the whole time reset is asserted.
  assign pc_write    = arst_n & ctl.pc_write;
  assign ifid_write  = arst_n & ctl.ifid_write;
  assign ifid_flush  = arst_n & ctl.ifid_flush;
  assign idex_bubble = arst_n & ctl.idex_bubble;
  assign pipe_hold   = arst_n & ctl.pipe_hold;
  assign mem_timeout = arst_n & ctl.mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (!pc_write && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
    if (ifid_flush && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: instance A (FLUSH_CYCLES=2, MEM_TIMEOUT=255) and B (FLUSH_CYCLES=1, MEM_TIMEOUT=3)
// share stimulus. Output vectors are {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout}.
module tb_hazard_control_unit;
  logic       clk = 1'b0;
  logic       arst_n;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic       id_uses_rs2, idex_mem_read, branch_taken_ex, mem_req, mem_ready;
  logic       pcw_a, ifw_a, ifl_a, bub_a, hld_a, to_a;
  logic       pcw_b, ifw_b, ifl_b, bub_b, hld_b, to_b;
  logic [5:0] oa, ob;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] pst_a, pfl_a, pst_b, pfl_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] O_ZERO = 6'b000000;
  localparam logic [5:0] O_DEF  = 6'b110000;
  localparam logic [5:0] O_LU   = 6'b000100;
  localparam logic [5:0] O_BR   = 6'b111100;
  localparam logic [5:0] O_HOLD = 6'b000010;
  localparam logic [5:0] O_TO   = 6'b000011;

  always #5 clk = ~clk;

  hazard_control_unit #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255)) u_a (
    .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .branch_taken_ex(branch_taken_ex),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pcw_a), .ifid_write(ifw_a),
    .ifid_flush(ifl_a), .idex_bubble(bub_a), .pipe_hold(hld_a),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cycles(pst_a), .perf_flush_cycles(pfl_a),
`endif
    .mem_timeout(to_a));

  hazard_control_unit #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(3)) u_b (
    .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read), .branch_taken_ex(branch_taken_ex),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pcw_b), .ifid_write(ifw_b),
    .ifid_flush(ifl_b), .idex_bubble(bub_b), .pipe_hold(hld_b),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cycles(pst_b), .perf_flush_cycles(pfl_b),
`endif
    .mem_timeout(to_b));

  assign oa = {pcw_a, ifw_a, ifl_a, bub_a, hld_a, to_a};
  assign ob = {pcw_b, ifw_b, ifl_b, bub_b, hld_b, to_b};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; idex_rd = 5'd0;
    idex_mem_read = 1'b0; branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance one clock, land 1 time unit after the edge; checks then happen 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5;
  endtask

  initial begin
    idle_in();
    arst_n = 1'b0;
    #1;
    chk("reset_a", oa, O_ZERO);
    chk("reset_b", ob, O_ZERO);
    cyc();
    arst_n = 1'b1;
    #1; chk("idle_a", oa, O_DEF); chk("idle_b", ob, O_DEF);

    // Load-use on rs1, then bubble clears it.
    cyc(); set_lu();
    #1; chk("lu_rs1_a", oa, O_LU); chk("lu_rs1_b", ob, O_LU);
    cyc(); idle_in();
    #1; chk("lu_after_a", oa, O_DEF);

    // Load-use via rs2 only when id_uses_rs2.
    cyc(); idex_mem_read = 1'b1; idex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1; chk("lu_rs2_a", oa, O_LU);
    cyc(); id_uses_rs2 = 1'b0;
    #1; chk("lu_rs2_unused_a", oa, O_DEF);
    cyc(); idle_in(); idex_mem_read = 1'b1;
    #1; chk("lu_rd0_a", oa, O_DEF);
    idex_mem_read = 1'b0; idex_rd = 5'd5; id_rs1 = 5'd5;
    #1; chk("no_load_a", oa, O_DEF);

    // Branch with simultaneous load-use: A flushes 2 cycles, B flushes 1.
    cyc(); idle_in(); set_lu(); branch_taken_ex = 1'b1;
    #1; chk("br1_a", oa, O_BR); chk("br1_b", ob, O_BR);
    cyc(); branch_taken_ex = 1'b0;
    #1; chk("br2_a", oa, O_BR); chk("br2_lu_b", ob, O_LU);
    cyc(); idle_in();
    #1; chk("br3_a", oa, O_DEF); chk("br3_b", ob, O_DEF);

    // Memory wait 4 cycles then ready; B (timeout 3) aborts on its 3rd wait cycle.
    cyc(); mem_req = 1'b1; mem_ready = 1'b0;
    #1; chk("mw1_a", oa, O_HOLD); chk("mw1_b", ob, O_HOLD);
    cyc(); #1; chk("mw2_a", oa, O_HOLD); chk("mw2_b", ob, O_HOLD);
    cyc(); #1; chk("mw3_a", oa, O_HOLD); chk("mw3_b", ob, O_HOLD);
    cyc(); #1; chk("mw4_a", oa, O_HOLD); chk("mw4_to_b", ob, O_TO);
    cyc(); mem_ready = 1'b1;
    #1; chk("mw5_a", oa, O_HOLD); chk("mw5_run_b", ob, O_DEF);
    cyc(); idle_in();
    #1; chk("mw6_a", oa, O_DEF); chk("mw6_b", ob, O_DEF);

    // Stall during FLUSH resumes the remaining flush cycle.
    cyc(); branch_taken_ex = 1'b1;
    #1; chk("fm1_a", oa, O_BR);
    cyc(); branch_taken_ex = 1'b0; mem_req = 1'b1;
    #1; chk("fm2_a", oa, O_HOLD);
    cyc(); mem_ready = 1'b1;
    #1; chk("fm3_a", oa, O_HOLD);
    cyc(); idle_in();
    #1; chk("fm4_a", oa, O_BR); chk("fm4_b", ob, O_DEF);
    cyc(); #1; chk("fm5_a", oa, O_DEF);

    // Memory stall outranks branch in RUN.
    cyc(); branch_taken_ex = 1'b1; mem_req = 1'b1;
    #1; chk("pri_a", oa, O_HOLD);
    cyc(); branch_taken_ex = 1'b0; mem_ready = 1'b1;
    #1; chk("pri_exit_a", oa, O_HOLD);
    cyc(); idle_in();
    #1; chk("pri_run_a", oa, O_DEF);

    // Reset in the middle of a flush.
    cyc(); branch_taken_ex = 1'b1;
    cyc(); branch_taken_ex = 1'b0;
    #1; chk("prerst_a", oa, O_BR);
    arst_n = 1'b0;
    #1; chk("midrst_a", oa, O_ZERO); chk("midrst_b", ob, O_ZERO);
    cyc(); arst_n = 1'b1;
    #1; chk("postrst_a", oa, O_DEF); chk("postrst_b", ob, O_DEF);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_rst", pst_a, 32'd0);
    chk("perf_flush_rst", pfl_a, 32'd0);
    set_lu();
    cyc(); idle_in(); branch_taken_ex = 1'b1;
    cyc(); idle_in();
    #1; chk("perf_stall_cnt", pst_a, 32'd1);
    chk("perf_flush_cnt", pfl_a, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
